// File: rtl/freq_mult_pkg.sv
// Shared types and constants for the frequency-multiplier measurement path.
package freq_mult_pkg;

  // Calibration sequencer states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    WAIT = 3'd2,
    MEAS = 3'd3,
    LOAD = 3'd4
  } state_t;

  // Default synchronizer depth for the asynchronous measured input.
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/in_sync_edge.sv
// Synchronizes an asynchronous input into the ref_f domain and flags
// its rising edges with a one-cycle pulse.
module in_sync_edge
  import freq_mult_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic ref_f,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain followed by one extra flop for edge detection.
  // NOTE: non-blocking assignments let every stage sample the previous
  // stage's old value on the same edge, forming a true shift chain.
  always_ff @(posedge ref_f) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meas_ctrl.sv
// Measurement sequencer: on an adjust request, times 2^AVG_LOG2 periods of
// in_freq in ref_f cycles and loads the averaged period for the divider.
// The accumulator doubles as the timeout counter while waiting for edges.
module freq_meas_ctrl
  import freq_mult_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int AVG_LOG2    = 2,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             ref_f,
  input  logic             rst,
  input  logic             in_freq,
  input  logic             adjust,
  output logic [CNT_W-1:0] period,
  output logic             ld,
  output logic             valid,
  output logic             busy,
  output logic             timeout
);

  localparam int                ACC_W     = CNT_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] EDGE_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q;
  logic [AVG_LOG2:0] edge_q;
  logic [CNT_W-1:0]  period_q;
  logic              timeout_q;
  logic              have_q;

  logic              rise;
  logic              acc_full;
  logic [CNT_W-1:0]  period_avg;
  logic              acc_clr, acc_inc;
  logic              edge_clr, edge_inc;
  logic              load_period;
  logic              set_timeout, clr_timeout;
  logic              set_have;

  in_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .ref_f (ref_f),
    .rst   (rst),
    .d     (in_freq),
    .rise  (rise)
  );

  assign acc_full = &acc_q;

  // acc holds (elapsed cycles - 1) at the final edge; the +1 is taken one bit
  // wider so an all-ones accumulator does not wrap before the divide.
  assign period_avg = CNT_W'(({1'b0, acc_q} + (ACC_W + 1)'(1)) >> AVG_LOG2);

  // Next-state and datapath control decode.
  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    acc_clr     = 1'b0;
    acc_inc     = 1'b0;
    edge_clr    = 1'b0;
    edge_inc    = 1'b0;
    load_period = 1'b0;
    set_timeout = 1'b0;
    clr_timeout = 1'b0;
    set_have    = 1'b0;
    case (state_q)
      IDLE: begin
        if (adjust) state_d = INIT;
      end
      INIT: begin
        acc_clr     = 1'b1;
        edge_clr    = 1'b1;
        clr_timeout = 1'b1;
        if (!adjust) state_d = WAIT;
      end
      WAIT: begin
        if (adjust) begin
          state_d = INIT;
        end else if (rise) begin
          acc_clr  = 1'b1;
          edge_clr = 1'b1;
          state_d  = MEAS;
        end else if (acc_full) begin
          set_timeout = 1'b1;
          state_d     = IDLE;
        end else begin
          acc_inc = 1'b1;
        end
      end
      MEAS: begin
        if (adjust) begin
          state_d = INIT;
        end else if (rise && (edge_q == EDGE_LAST)) begin
          load_period = 1'b1;
          state_d     = LOAD;
        end else if (acc_full) begin
          set_timeout = 1'b1;
          state_d     = IDLE;
        end else begin
          acc_inc  = 1'b1;
          edge_inc = rise;
        end
      end
      LOAD: begin
        if (adjust) begin
          state_d = INIT;
        end else begin
          set_have = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, accumulator, edge counter and output registers.
  always_ff @(posedge ref_f) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      edge_q    <= '0;
      period_q  <= '0;
      timeout_q <= 1'b0;
      have_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc_clr)       acc_q <= '0;
      else if (acc_inc)  acc_q <= acc_q + ACC_W'(1);
      if (edge_clr)      edge_q <= '0;
      else if (edge_inc) edge_q <= edge_q + (AVG_LOG2 + 1)'(1);
      if (load_period)   period_q <= period_avg;
      if (set_timeout)      timeout_q <= 1'b1;
      else if (clr_timeout) timeout_q <= 1'b0;
      if (set_timeout)   have_q <= 1'b0;
      else if (set_have) have_q <= 1'b1;
    end
  end

  // A restart request during LOAD suppresses the load strobe.
  assign ld      = (state_q == LOAD) && !adjust;
  assign valid   = (state_q == IDLE) && have_q;
  assign busy    = (state_q != IDLE);
  assign timeout = timeout_q;
  assign period  = period_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Self-checking bench for freq_meas_ctrl: a timestamp-based reference model
// for the 16-bit instance checked every cycle, plus literal checks on both
// a 16-bit and an 8-bit (fast timeout) instance sharing the same stimulus.
module tb_freq_meas_ctrl;

  localparam int S     = 2;
  localparam int N     = 4;
  localparam int MAXC  = (1 << 18) - 1;

  logic ref_f   = 1'b0;
  logic rst     = 1'b1;
  logic in_freq = 1'b0;
  logic adjust  = 1'b0;

  logic [15:0] period16;
  logic        ld16, valid16, busy16, timeout16;
  logic [7:0]  period8;
  logic        ld8, valid8, busy8, timeout8;

  int n_checks = 0;
  int n_fail   = 0;
  int ld16_cnt = 0;
  int ld8_cnt  = 0;

  always #5 ref_f = ~ref_f;

  freq_meas_ctrl #(.CNT_W(16), .AVG_LOG2(2), .SYNC_STAGES(S)) dut16 (
    .ref_f(ref_f), .rst(rst), .in_freq(in_freq), .adjust(adjust),
    .period(period16), .ld(ld16), .valid(valid16), .busy(busy16), .timeout(timeout16)
  );

  freq_meas_ctrl #(.CNT_W(8), .AVG_LOG2(2), .SYNC_STAGES(S)) dut8 (
    .ref_f(ref_f), .rst(rst), .in_freq(in_freq), .adjust(adjust),
    .period(period8), .ld(ld8), .valid(valid8), .busy(busy8), .timeout(timeout8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (16-bit instance) ----------------
  typedef enum {M_IDLE, M_INIT, M_WAIT, M_MEAS, M_LOAD} phase_t;
  phase_t      mode     = M_IDLE;
  bit [15:0]   m_period = '0;
  bit          m_to     = 1'b0;
  bit          m_have   = 1'b0;
  int          cyc      = 0;
  int          t_mark   = 0;
  int          nrise    = 0;
  bit          samp [0:S] = '{default: 1'b0};

  // samp[0] is the pin sample from the previous edge; a rise is seen at this
  // edge when the sample S edges back is high and the one before it low.
  always @(posedge ref_f) begin : model
    bit r;
    cyc++;
    r = samp[S-1] && !samp[S];
    if (rst) begin
      mode = M_IDLE; m_period = '0; m_to = 1'b0; m_have = 1'b0;
      for (int i = 0; i <= S; i++) samp[i] = 1'b0;
    end else begin
      for (int i = S; i > 0; i--) samp[i] = samp[i-1];
      samp[0] = in_freq;
      case (mode)
        M_IDLE: if (adjust) mode = M_INIT;
        M_INIT: begin
          m_to = 1'b0;
          if (!adjust) begin mode = M_WAIT; t_mark = cyc; end
        end
        M_WAIT: begin
          if (adjust) mode = M_INIT;
          else if (r) begin mode = M_MEAS; t_mark = cyc; nrise = 0; end
          else if (cyc - t_mark - 1 == MAXC) begin mode = M_IDLE; m_to = 1'b1; m_have = 1'b0; end
        end
        M_MEAS: begin
          if (adjust) mode = M_INIT;
          else if (r && nrise == N - 1) begin
            m_period = 16'((cyc - t_mark) / N);
            mode = M_LOAD;
          end else if (cyc - t_mark - 1 == MAXC) begin mode = M_IDLE; m_to = 1'b1; m_have = 1'b0; end
          else if (r) nrise++;
        end
        M_LOAD: begin
          if (adjust) mode = M_INIT;
          else begin m_have = 1'b1; mode = M_IDLE; end
        end
        default: mode = M_IDLE;
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge ref_f) begin
    check("period", 32'(period16), 32'(m_period));
    check("ld", 32'(ld16), 32'((mode == M_LOAD) && !adjust));
    check("valid", 32'(valid16), 32'((mode == M_IDLE) && m_have));
    check("busy", 32'(busy16), 32'(mode != M_IDLE));
    check("timeout", 32'(timeout16), 32'(m_to));
    if (ld16) ld16_cnt++;
    if (ld8)  ld8_cnt++;
  end

  // ---------------- stimulus ----------------
  int wave_q [$];
  int per_q  [$];
  bit lvl = 1'b0;
  int rem = 0;

  task automatic add_period(input int p, input int hi);
    wave_q.push_back(hi);
    wave_q.push_back(p - hi);
  endtask

  task automatic step(input bit adj, input bit r);
    @(posedge ref_f);
    #1;
    if (rem == 0 && wave_q.size() > 0) begin
      lvl = ~lvl;
      rem = wave_q.pop_front();
    end
    if (rem > 0) rem--;
    in_freq = lvl;
    adjust  = adj;
    rst     = r;
  endtask

  task automatic run(input int n, input bit adj);
    repeat (n) step(adj, 1'b0);
  endtask

  task automatic measure(input int exp_p);
    int base;
    int total;
    base  = ld16_cnt;
    total = 0;
    run(3, 1'b1);
    foreach (per_q[i]) begin
      add_period(per_q[i], per_q[i] / 2);
      total += per_q[i];
    end
    per_q.delete();
    run(total + 12, 1'b0);
    check("meas_ld_count", ld16_cnt - base, 1);
    check("meas_period", 32'(period16), exp_p);
    check("meas_valid", 32'(valid16), 1);
    check("meas_timeout", 32'(timeout16), 0);
    check("model_period", 32'(m_period), exp_p);
  endtask

  initial begin
    int base;
    int n;

    // Reset while the input toggles.
    add_period(6, 3);
    add_period(6, 3);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("rst_period", 32'(period16), 0);
    check("rst_ld", 32'(ld16), 0);
    check("rst_valid", 32'(valid16), 0);
    check("rst_busy", 32'(busy16), 0);
    check("rst_timeout", 32'(timeout16), 0);
    run(14, 1'b0);
    check("rst_idle_busy", 32'(busy16), 0);

    // Clean 40-cycle input.
    repeat (5) per_q.push_back(40);
    measure(40);

    // Alternating 39/41 averages to 40; steady 43 gives 43.
    per_q = '{39, 41, 39, 41, 39};
    measure(40);
    repeat (5) per_q.push_back(43);
    measure(43);

    // Restart after two edges in MEAS, then a complete measurement.
    base = ld16_cnt;
    run(3, 1'b1);
    repeat (9) add_period(36, 18);
    run(100, 1'b0);
    check("rs_busy_meas", 32'(busy16), 1);
    run(3, 1'b1);
    check("rs_no_ld", ld16_cnt - base, 0);
    run(9 * 36 - 103 + 20, 1'b0);
    check("rs_ld_count", ld16_cnt - base, 1);
    check("rs_period", 32'(period16), 36);
    check("rs_valid", 32'(valid16), 1);

    // Reset pulse in the middle of a measurement.
    run(2, 1'b1);
    repeat (8) add_period(30, 15);
    run(60, 1'b0);
    check("mr_busy_before", 32'(busy16), 1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("mr_period", 32'(period16), 0);
    check("mr_ld", 32'(ld16), 0);
    check("mr_valid", 32'(valid16), 0);
    check("mr_busy", 32'(busy16), 0);
    check("mr_timeout", 32'(timeout16), 0);
    wave_q.delete();
    rem = 0;
    lvl = 1'b0;
    run(6, 1'b0);
    repeat (5) per_q.push_back(25);
    measure(25);

    // Randomized periods, duty cycles, adjust lengths and restarts.
    for (int it = 0; it < 8; it++) begin
      int cnt, adj_len, rs_at, total, p, hi;
      adj_len = $urandom_range(1, 4);
      cnt     = $urandom_range(4, 7);
      total   = 0;
      if ($urandom_range(0, 1) == 1) add_period(12, 6);
      run(adj_len, 1'b1);
      for (int j = 0; j < cnt; j++) begin
        p  = $urandom_range(6, 60);
        hi = $urandom_range(2, p - 2);
        add_period(p, hi);
        total += p;
      end
      rs_at = ($urandom_range(0, 3) == 0) ? $urandom_range(10, total) : -1;
      for (int c = 0; c < total + 27; c++) step((c == rs_at) || (c == rs_at + 1), 1'b0);
    end

    // Timeout on the 8-bit instance: previous period 40, input stuck low.
    repeat (5) per_q.push_back(40);
    measure(40);
    check("to8_pre_period", 32'(period8), 40);
    check("to8_pre_valid", 32'(valid8), 1);
    base = ld8_cnt;
    run(2, 1'b1);
    n = 0;
    do begin
      step(1'b0, 1'b0);
      n++;
    end while (busy8 && n < 1100);
    check("to8_cycles", n, 1026);
    check("to8_timeout", 32'(timeout8), 1);
    check("to8_valid", 32'(valid8), 0);
    check("to8_period", 32'(period8), 40);
    check("to8_no_ld", ld8_cnt - base, 0);
    run(4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
